// File: rtl/sync_count_tracker.sv
// -----------------------------------------------------------------------------
// sync_count_tracker
//
// Qualifies a binary counter value coming out of a gray-coded CDC synchronizer
// and accumulates the modulo step between accepted values.
//
// A new value is accepted only after it has been sampled unchanged for
// g_STABLE_CYCLES consecutive cycles. The modulo step since the last accepted
// value is then added to a wide, saturating total. Steps larger than
// g_MAX_STEP raise a sticky error and are not added to the total, but the
// accepted value still moves to the new count.
//
// The total is read through a 4-phase snapshot handshake.
//
// Optional build macro:
//   TRACKER_CLEAR_ON_SNAP_EN
//     Each snapshot capture clears the total, so every snapshot reads as a
//     delta since the previous one. The default build (macro undefined) keeps
//     the total cumulative until reset.
//
// Ports:
//   DEST_CLOCK_I  in   destination clock; all logic is on its rising edge
//   RESET_I       in   synchronous, active-high reset
//   enable_i      in   tracking enable (level)
//   sync_count_i  in   counter value from the synchronizer output
//   snap_req_i    in   snapshot request (4-phase)
//   clear_err_i   in   clears step_err_o and sat_o
//   snap_ack_o    out  snapshot acknowledge
//   snap_total_o  out  captured total
//   cur_count_o   out  last accepted counter value
//   step_o        out  last accepted modulo step
//   update_o      out  one-cycle pulse per accepted value
//   step_err_o    out  sticky: a step exceeded g_MAX_STEP
//   sat_o         out  sticky: the total saturated
//   dbg_state_o   out  current FSM state (S_IDLE=0, S_BASE=1, S_TRACK=2,
//                      S_QUAL=3)
//
// Snapshot handshake:
//   A capture happens on an edge where snap_req_i=1 and snap_ack_o=0. On that
//   edge snap_total_o loads the total and snap_ack_o rises. snap_ack_o then
//   stays high until an edge where snap_req_i=0. A further capture needs a
//   fresh request.
// -----------------------------------------------------------------------------
module sync_count_tracker #(
  parameter int g_BUS_WIDTH     = 16,
  parameter int g_STABLE_CYCLES = 2,
  parameter int g_MAX_STEP      = 4,
  parameter int g_ACC_WIDTH     = 32
) (
  input  logic                   DEST_CLOCK_I,
  input  logic                   RESET_I,
  input  logic                   enable_i,
  input  logic [g_BUS_WIDTH-1:0] sync_count_i,
  input  logic                   snap_req_i,
  output logic                   snap_ack_o,
  output logic [g_ACC_WIDTH-1:0] snap_total_o,
  output logic [g_BUS_WIDTH-1:0] cur_count_o,
  output logic [g_BUS_WIDTH-1:0] step_o,
  output logic                   update_o,
  output logic                   step_err_o,
  output logic                   sat_o,
  input  logic                   clear_err_i,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BASE  = 2'd1,
    S_TRACK = 2'd2,
    S_QUAL  = 2'd3
  } state_t;

  localparam logic [3:0]             STABLE_C   = 4'(g_STABLE_CYCLES);
  localparam logic [g_BUS_WIDTH-1:0] MAX_STEP_C = g_BUS_WIDTH'(g_MAX_STEP);

  state_t                 state;
  logic [g_BUS_WIDTH-1:0] candidate;
  logic [3:0]             stable_cnt;
  logic [g_ACC_WIDTH-1:0] total;

  // Combinational datapath for the accept decision.
  logic                   acc_fire;
  logic [g_BUS_WIDTH-1:0] acc_val;
  logic [g_BUS_WIDTH-1:0] step;
  logic                   step_ok;
  logic [g_ACC_WIDTH-1:0] step_ext;
  logic [g_ACC_WIDTH:0]   sum;
  logic                   add_fire;
  logic                   snap_cap;
  logic                   sat_set;
  logic [g_ACC_WIDTH-1:0] total_next;

  assign dbg_state_o = state;

  always_comb begin
    acc_fire = 1'b0;
    acc_val  = candidate;
    if (enable_i) begin
      case (state)
        // With a single-cycle qualifier, the first differing sample is
        // already stable enough to accept.
        S_TRACK: begin
          if ((sync_count_i != cur_count_o) && (STABLE_C == 4'd1)) begin
            acc_fire = 1'b1;
            acc_val  = sync_count_i;
          end
        end
        S_QUAL: begin
          if ((sync_count_i == candidate) && ((stable_cnt + 4'd1) == STABLE_C)) begin
            acc_fire = 1'b1;
            acc_val  = candidate;
          end
        end
        default: ;
      endcase
    end
  end

  // Unsigned subtraction wraps, which gives the modulo step directly.
  assign step     = acc_val - cur_count_o;
  assign step_ok  = (step <= MAX_STEP_C);
  assign step_ext = g_ACC_WIDTH'(step);
  assign sum      = {1'b0, total} + {1'b0, step_ext};
  assign add_fire = acc_fire && step_ok;
  assign snap_cap = snap_req_i && !snap_ack_o;

  always_comb begin
    total_next = total;
    sat_set    = 1'b0;
`ifdef TRACKER_CLEAR_ON_SNAP_EN
    // A capture clears the total. If a step is being added on the same edge,
    // that step alone starts the next delta so no count is lost.
    if (snap_cap) begin
      total_next = add_fire ? step_ext : '0;
    end else if (add_fire) begin
      total_next = sum[g_ACC_WIDTH] ? '1 : sum[g_ACC_WIDTH-1:0];
      sat_set    = sum[g_ACC_WIDTH];
    end
`else
    if (add_fire) begin
      total_next = sum[g_ACC_WIDTH] ? '1 : sum[g_ACC_WIDTH-1:0];
      sat_set    = sum[g_ACC_WIDTH];
    end
`endif
  end

  always_ff @(posedge DEST_CLOCK_I) begin
    if (RESET_I) begin
      state        <= S_IDLE;
      candidate    <= '0;
      stable_cnt   <= '0;
      total        <= '0;
      cur_count_o  <= '0;
      step_o       <= '0;
      update_o     <= 1'b0;
      step_err_o   <= 1'b0;
      sat_o        <= 1'b0;
      snap_ack_o   <= 1'b0;
      snap_total_o <= '0;
    end else begin
      update_o <= acc_fire;
      total    <= total_next;

      // A set event on the same edge as a clear wins.
      step_err_o <= (acc_fire && !step_ok) || (step_err_o && !clear_err_i);
      sat_o      <= sat_set || (sat_o && !clear_err_i);

      // The capture takes the pre-accept total; the step shows up next time.
      if (snap_cap) begin
        snap_total_o <= total;
        snap_ack_o   <= 1'b1;
      end else if (!snap_req_i) begin
        snap_ack_o <= 1'b0;
      end

      if (acc_fire) begin
        step_o <= step;
      end

      if (!enable_i) begin
        // Dropping enable discards any in-flight candidate. Re-enabling always
        // passes through S_BASE, so no step is measured across the gap.
        state      <= S_IDLE;
        stable_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_BASE;
          end
          S_BASE: begin
            cur_count_o <= sync_count_i;
            state       <= S_TRACK;
          end
          S_TRACK: begin
            if (sync_count_i != cur_count_o) begin
              if (acc_fire) begin
                cur_count_o <= acc_val;
              end else begin
                candidate  <= sync_count_i;
                stable_cnt <= 4'd1;
                state      <= S_QUAL;
              end
            end
          end
          S_QUAL: begin
            if (sync_count_i == candidate) begin
              if (acc_fire) begin
                cur_count_o <= acc_val;
                stable_cnt  <= '0;
                state       <= S_TRACK;
              end else begin
                stable_cnt <= stable_cnt + 4'd1;
              end
            end else if (sync_count_i == cur_count_o) begin
              // The input fell back to the accepted value, so the candidate
              // was only a glitch.
              stable_cnt <= '0;
              state      <= S_TRACK;
            end else begin
              candidate  <= sync_count_i;
              stable_cnt <= 4'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sync_count_tracker.sv
module tb_sync_count_tracker;

  logic clk;
  logic rst;

  // Main instance: default parameters.
  logic        m_en, m_req, m_clr;
  logic [15:0] m_sync;
  logic        m_ack, m_update, m_err, m_sat;
  logic [31:0] m_snap;
  logic [15:0] m_cur, m_step;
  logic [1:0]  m_state;

  // Saturation instance: 16-bit total, any step legal.
  logic        s_en, s_req, s_clr;
  logic [15:0] s_sync;
  logic        s_ack, s_update, s_err, s_sat;
  logic [15:0] s_snap;
  logic [15:0] s_cur, s_step;
  logic [1:0]  s_state;

  int checks   = 0;
  int failures = 0;

  // Update record: {step_err, step, cur_count}.
  logic [32:0] m_upd_q[$];
  logic [32:0] s_upd_q[$];
  logic [31:0] m_snap_q[$];
  logic [31:0] s_snap_q[$];
  logic        m_ack_prev = 1'b0;
  logic        s_ack_prev = 1'b0;

  sync_count_tracker u_main (
    .DEST_CLOCK_I (clk),
    .RESET_I      (rst),
    .enable_i     (m_en),
    .sync_count_i (m_sync),
    .snap_req_i   (m_req),
    .snap_ack_o   (m_ack),
    .snap_total_o (m_snap),
    .cur_count_o  (m_cur),
    .step_o       (m_step),
    .update_o     (m_update),
    .step_err_o   (m_err),
    .sat_o        (m_sat),
    .clear_err_i  (m_clr),
    .dbg_state_o  (m_state)
  );

  sync_count_tracker #(
    .g_BUS_WIDTH     (16),
    .g_STABLE_CYCLES (2),
    .g_MAX_STEP      (16'hFFFF),
    .g_ACC_WIDTH     (16)
  ) u_sat (
    .DEST_CLOCK_I (clk),
    .RESET_I      (rst),
    .enable_i     (s_en),
    .sync_count_i (s_sync),
    .snap_req_i   (s_req),
    .snap_ack_o   (s_ack),
    .snap_total_o (s_snap),
    .cur_count_o  (s_cur),
    .step_o       (s_step),
    .update_o     (s_update),
    .step_err_o   (s_err),
    .sat_o        (s_sat),
    .clear_err_i  (s_clr),
    .dbg_state_o  (s_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitors: pop and compare whenever the DUT presents an event.
  always @(negedge clk) begin
    if (m_update) begin
      if (m_upd_q.size() == 0) check("m_update_unexpected", {m_err, m_step, m_cur}, 64'hDEAD);
      else check("m_update", {m_err, m_step, m_cur}, m_upd_q.pop_front());
    end
    if (m_ack && !m_ack_prev) begin
      if (m_snap_q.size() == 0) check("m_snap_unexpected", m_snap, 64'hDEAD);
      else check("m_snap", m_snap, m_snap_q.pop_front());
    end
    m_ack_prev = m_ack;
    if (s_update) begin
      if (s_upd_q.size() == 0) check("s_update_unexpected", {s_err, s_step, s_cur}, 64'hDEAD);
      else check("s_update", {s_err, s_step, s_cur}, s_upd_q.pop_front());
    end
    if (s_ack && !s_ack_prev) begin
      if (s_snap_q.size() == 0) check("s_snap_unexpected", s_snap, 64'hDEAD);
      else check("s_snap", s_snap, s_snap_q.pop_front());
    end
    s_ack_prev = s_ack;
  end

  // Holds a value long enough for a two-cycle qualifier to accept it and for
  // the update pulse to be seen.
  task automatic m_settle(input logic [15:0] v, input logic err, input logic [15:0] stp);
    m_sync = v;
    m_upd_q.push_back({err, stp, v});
    tick(3);
  endtask

  task automatic s_settle(input logic [15:0] v, input logic [15:0] stp);
    s_sync = v;
    s_upd_q.push_back({1'b0, stp, v});
    tick(3);
  endtask

  initial begin
    rst = 1'b1;
    m_en = 0; m_req = 0; m_clr = 0; m_sync = 16'h0;
    s_en = 0; s_req = 0; s_clr = 0; s_sync = 16'h0;
    tick(3);

    // Reset state
    check("rst_cur", m_cur, 0);
    check("rst_step", m_step, 0);
    check("rst_update", m_update, 0);
    check("rst_err", m_err, 0);
    check("rst_sat", m_sat, 0);
    check("rst_ack", m_ack, 0);
    check("rst_snap", m_snap, 0);
    check("rst_state", m_state, 0);
    rst = 1'b0;

    // 1: base 0x0010, then 0x0013 held two cycles -> step 3, total 3
    m_en = 1; m_sync = 16'h0010;
    tick(2);
    check("base_cur", m_cur, 16'h0010);
    m_settle(16'h0013, 1'b0, 16'd3);

    // 2: one-cycle glitch is discarded, then 0x14 -> 0x15 -> 0x15 accepts 0x15
    m_sync = 16'h0014; tick(1);
    m_sync = 16'h0013; tick(2);
    check("glitch_cur", m_cur, 16'h0013);
    m_sync = 16'h0014; tick(1);
    m_settle(16'h0015, 1'b0, 16'd2);          // total 5

    // 3: wrap from 0xFFFE to 0x0001 is step 3, then an oversized step
    m_en = 0; tick(1);
    m_sync = 16'hFFFE; m_en = 1; tick(2);
    check("rebase_cur", m_cur, 16'hFFFE);
    m_settle(16'h0001, 1'b0, 16'd3);          // total 8
    m_settle(16'h0100, 1'b1, 16'h00FF);       // total unchanged
    check("err_set", m_err, 1);
    m_clr = 1; tick(1); m_clr = 0;
    check("err_clr", m_err, 0);
    m_settle(16'h0102, 1'b0, 16'd2);          // total 10

    // 5: snapshot on the same edge as an accept of step 2
    m_sync = 16'h0104;
    m_upd_q.push_back({1'b0, 16'd2, 16'h0104});
    m_snap_q.push_back(32'd10);
    tick(1);
    m_req = 1; tick(1);
    for (int i = 0; i < 3; i++) begin
      check("ack_hold", {m_ack, m_snap}, {1'b1, 32'd10});
      tick(1);
    end
    m_req = 0; tick(1);
    check("ack_drop", m_ack, 0);
`ifdef TRACKER_CLEAR_ON_SNAP_EN
    m_snap_q.push_back(32'd2);
`else
    m_snap_q.push_back(32'd12);
`endif
    m_req = 1; tick(1);
    check("ack_second", m_ack, 1);
    m_req = 0; tick(2);

    // 6: disable mid-qualification, jump while disabled, re-enable
    m_en = 0; m_sync = 16'h0020; tick(1);
    m_en = 1; tick(2);
    check("base20_cur", m_cur, 16'h0020);
    m_sync = 16'h0021; tick(1);
    check("qual_state", m_state, 3);
    m_en = 0; tick(1);
    check("idle_state", m_state, 0);
    m_sync = 16'h0800; tick(1);
    m_en = 1; tick(4);
    check("jump_cur", m_cur, 16'h0800);
    check("jump_err", m_err, 0);
    check("jump_step", m_step, 16'd2);

`ifdef TRACKER_CLEAR_ON_SNAP_EN
    m_snap_q.push_back(32'd0);
`else
    m_snap_q.push_back(32'd12);
`endif
    m_req = 1; tick(1);
    check("ack_pre_rst", m_ack, 1);
    rst = 1; tick(1);
    check("mid_rst", {m_ack, m_snap, m_cur, m_state}, 0);
    m_en = 0;
    m_snap_q.push_back(32'd0);              // request still high: total now 0
    rst = 0; tick(1);
    check("post_rst_ack", m_ack, 1);
    m_req = 0; tick(2);

    // 4: saturation on the 16-bit instance
    s_en = 1; s_sync = 16'h0000; tick(2);
    s_settle(16'h8000, 16'h8000);            // total 0x8000
    s_settle(16'hFFFD, 16'h7FFD);            // total 0xFFFD
    check("no_sat_yet", s_sat, 0);
    s_settle(16'h0001, 16'd4);               // overflow -> 0xFFFF
    check("sat_set", s_sat, 1);
    s_snap_q.push_back(32'hFFFF);
    s_req = 1; tick(1);
    s_req = 0; tick(1);
    s_clr = 1; tick(1); s_clr = 0;
    check("sat_clr", s_sat, 0);
    tick(2);

    check("m_upd_q_empty", m_upd_q.size(), 0);
    check("m_snap_q_empty", m_snap_q.size(), 0);
    check("s_upd_q_empty", s_upd_q.size(), 0);
    check("s_snap_q_empty", s_snap_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_count_tracker.md
Name: sync_count_tracker

Overview:
Destination-domain qualifier and accumulator for a binary counter delivered through the gray-coded bus CDC synchronizer (e.g. byte/line counters crossing from the MIPI byte clock). It only accepts a new synchronized value after it has been stable for a set number of cycles. It then computes the modulo step since the last accepted value and accumulates it into a wide saturating total. The total is exposed through a 4-phase snapshot handshake for the register interface, and step-size violations are flagged.

Parameters:
g_BUS_WIDTH, 16, width of synchronized counter input
g_STABLE_CYCLES, 2, consecutive identical samples required to accept a value (legal range 1..15)
g_MAX_STEP, 4, largest legal modulo step between accepted values (legal range 1..2^g_BUS_WIDTH-1)
g_ACC_WIDTH, 32, width of accumulated total (must be >= g_BUS_WIDTH)

Ports:
DEST_CLOCK_I  in  1  destination clock; all logic is on its rising edge
RESET_I  in  1  synchronous, active-high reset
enable_i  in  1  tracking enable (level)
sync_count_i  in  g_BUS_WIDTH  binary counter value from the synchronizer output
snap_req_i  in  1  snapshot request (4-phase)
snap_ack_o  out  1  snapshot acknowledge
snap_total_o  out  g_ACC_WIDTH  captured total
cur_count_o  out  g_BUS_WIDTH  last accepted counter value
step_o  out  g_BUS_WIDTH  last accepted modulo step
update_o  out  1  one-cycle pulse per accepted value
step_err_o  out  1  sticky flag: step exceeded g_MAX_STEP
sat_o  out  1  sticky flag: total saturated
clear_err_i  in  1  clears step_err_o and sat_o

Behaviour:
- Reset (RESET_I=1 at a clock edge): state=S_IDLE. All outputs, total, candidate and stability counter go to 0. Reset overrides every other input, including mid-qualification and mid-handshake.
- S_IDLE: outputs hold their values. enable_i=1 -> S_BASE.
- S_BASE: accepted<=sync_count_i (cur_count_o updates). No update_o pulse, no total change. -> S_TRACK.
- S_TRACK: if sync_count_i != accepted, then candidate<=sync_count_i and cnt<=1.
  - If g_STABLE_CYCLES=1, the value is accepted on this same edge.
  - Otherwise -> S_QUAL.
- S_QUAL, per sample:
  - sync_count_i==candidate: cnt++. When cnt reaches g_STABLE_CYCLES, accept and return to S_TRACK.
  - sync_count_i==accepted: discard the candidate -> S_TRACK.
  - Any other value: candidate<=sync_count_i, cnt<=1, stay in S_QUAL.
- Accept action:
  - step=(candidate-accepted) mod 2^g_BUS_WIDTH. step_o<=step, cur_count_o<=candidate, update_o=1 for exactly one cycle.
  - If step>g_MAX_STEP: step_err_o<=1 and the total is unchanged (accepted value still resyncs).
  - Otherwise: total<=total+step, saturating at 2^g_ACC_WIDTH-1, with sat_o<=1 when the add would overflow.
  - Wrap-around (e.g. 0xFFFF->0x0001) yields step 2 with no error.
- Latency: outputs reflect a new value in the cycle after the g_STABLE_CYCLES-th consecutive matching sample. The first differing sample counts as sample 1.
- enable_i=0 in any state: -> S_IDLE on that edge. Any in-flight candidate is discarded. Total and flags are retained. Re-enable always passes through S_BASE, so there is no step across the disabled gap.
- Snapshot handshake:
  - When snap_req_i=1 and snap_ack_o=0: snap_total_o<=total and snap_ack_o<=1 on that edge.
  - snap_ack_o stays 1 until a cycle where snap_req_i=0, and clears on that edge. A new capture requires a fresh request.
  - If an accept occurs on the capture edge, the snapshot holds the pre-accept total; the step appears in the next snapshot.
- clear_err_i=1 clears step_err_o and sat_o. A set event on the same edge wins (flag stays 1). Clearing does not change the total.

Optional Feature:
TRACKER_CLEAR_ON_SNAP_EN.
- Defined: each snapshot capture atomically clears the total, so snap_total_o is a delta since the previous snapshot. If an accept occurs on the capture edge, total<=step of that accept, so no count is lost. sat_o is still sticky, cleared only by clear_err_i.
- Undefined: the total is never cleared except by reset; snapshots are cumulative.

Test Plan:
1. Reset, enable, sync_count_i=0x0010 held, then 0x0013 held 2 cycles -> cur_count_o=0x0013, step_o=3, one update_o pulse, total=3, step_err_o=0.
2. Glitch: sync_count_i 0x0013 -> 0x0014 for 1 cycle -> 0x0013 -> no update_o, total unchanged. Then 0x0014 -> 0x0015 -> 0x0015 -> accepts 0x0015 with step 2.
3. Wrap: accepted 0xFFFE, input 0x0001 stable -> step_o=3, no error. Then input 0x0100 stable -> step_err_o=1, total unchanged, cur_count_o=0x0100. clear_err_i pulse -> step_err_o=0.
4. Saturation with g_ACC_WIDTH=16, g_BUS_WIDTH=16, g_MAX_STEP=0xFFFF: force total to 0xFFFD, then step 4 -> total=0xFFFF, sat_o=1.
5. Snapshot coinciding with an accept of step 2, total 10 -> snap_total_o=10, snap_ack_o=1 until snap_req_i drops. Next snapshot returns 12; with TRACKER_CLEAR_ON_SNAP_EN it returns 2.
6. enable_i dropped mid-qualification, input jumps 0x0020 -> 0x0800, then re-enabled -> no update_o, no step_err_o, cur_count_o=0x0800. Assert RESET_I mid-handshake -> snap_ack_o=0, total=0 on the next edge.
